// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the instruction sequencer: the FSM state encoding,
// datapath widths, the opcodes the sequencer itself has to recognise, and a
// helper that extracts the opcode field from an instruction word (iiiidddddd).
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 10;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_RST   = 4'b0111;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b1011;
    localparam logic [OP_W-1:0] OP_STORE = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_COMMIT  = 3'd4,
        S_MEMWAIT = 3'd5,
        S_HALT    = 3'd6
    } seq_state_t;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// -----------------------------------------------------------------------------
// seq_pc_unit
// Program counter register and its next-value mux.
// Ports:
//   clk       in   sole clock
//   reset     in   asynchronous active-high reset (pc -> 0)
//   i_upd     in   load the selected next value into the pc this cycle
//   i_load    in   select i_target (decoder jump)
//   i_clear   in   select zero (reset opcode); lower priority than i_load
//   i_target  in   jump target
//   o_pc      out  current program counter
// With neither select asserted the pc increments, wrapping 0xFF -> 0x00.
// -----------------------------------------------------------------------------
module seq_pc_unit
    import cpu_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_upd,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc + PC_W'(1);
        if (i_load) begin
            w_pc_next = i_target;
        end else if (i_clear) begin
            w_pc_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (i_upd) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Fetch / decode / execute / commit control FSM for a small CPU. Fetches a
// 10-bit word from instruction memory at pc, holds it in the instruction
// register, strobes exec_en for one cycle, then advances the pc (jump, reset
// opcode, or increment). LOAD/STORE wait in MEMWAIT for dmem_done first.
// A sticky halt request stops the core after the current instruction.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   run                   start from IDLE or leave HALT
//   halt_req              request halt after the current instruction
//   imem_req/imem_addr    instruction fetch request and address (= pc)
//   imem_ack/imem_rdata   fetch data strobe and data
//   instr                 instruction register
//   exec_en               one-cycle execute strobe for the decoder
//   load_PC/pc_value      decoder jump request / target, sampled in COMMIT
//   dmem_done             data-memory completion, sampled in MEMWAIT
//   pc, state, halted     status
//   step                  (only with SEQ_SINGLE_STEP_EN) run one instruction
//                         from HALT and return to HALT
//
// Build option: define SEQ_SINGLE_STEP_EN to add the step input.
// -----------------------------------------------------------------------------
module instr_sequencer
    import cpu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               halt_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               exec_en,
    input  logic               load_PC,
    input  logic [PC_W-1:0]    pc_value,
    input  logic               dmem_done,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               halted
);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_halt_pend;
    logic                r_step_mode;
    logic [PC_W-1:0]     w_pc;
    logic [OP_W-1:0]     w_op;
    logic                w_mem_op;
    logic                w_stop_after;
    logic                w_pc_upd;
    logic                w_pc_load;
    logic                w_pc_clear;
    logic                w_instr_cap;
    logic                w_halt_exit;
    logic                w_step_start;
    seq_state_t          w_after_upd;

    assign w_op     = opcode_of(r_instr);
    assign w_mem_op = (w_op == OP_LOAD) || (w_op == OP_STORE);

    // A halt request arriving in the very cycle the pc updates still counts,
    // and a single-stepped instruction always goes back to HALT.
    assign w_stop_after = r_halt_pend || halt_req || r_step_mode;
    assign w_after_upd  = w_stop_after ? S_HALT : S_FETCH;

    always_comb begin
        w_state_next = r_state;
        w_pc_upd     = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_clear   = 1'b0;
        w_instr_cap  = 1'b0;
        w_halt_exit  = 1'b0;
        w_step_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_cap  = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_COMMIT;
            S_COMMIT: begin
                if (w_mem_op) begin
                    w_state_next = S_MEMWAIT;
                end else begin
                    w_pc_upd     = 1'b1;
                    w_pc_load    = load_PC;
                    w_pc_clear   = (w_op == OP_RST);
                    w_state_next = w_after_upd;
                end
            end
            S_MEMWAIT: begin
                if (dmem_done) begin
                    w_pc_upd     = 1'b1;
                    w_state_next = w_after_upd;
                end
            end
            S_HALT: begin
                // run together with halt_req keeps the core parked.
                if (run) begin
                    if (!halt_req) begin
                        w_halt_exit  = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                else if (step) begin
                    w_halt_exit  = 1'b1;
                    w_step_start = 1'b1;
                    w_state_next = S_FETCH;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_halt_pend <= 1'b0;
            r_step_mode <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_instr_cap) r_instr <= imem_rdata;
            if (w_halt_exit) begin
                r_halt_pend <= 1'b0;
            end else if (halt_req) begin
                r_halt_pend <= 1'b1;
            end
            if (w_halt_exit) r_step_mode <= w_step_start;
        end
    end

    seq_pc_unit u_pc (
        .clk      (clk),
        .reset    (reset),
        .i_upd    (w_pc_upd),
        .i_load   (w_pc_load),
        .i_clear  (w_pc_clear),
        .i_target (pc_value),
        .o_pc     (w_pc)
    );

    // Outputs decode directly from the state register so reset clears them
    // immediately, without waiting for a clock edge.
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = w_pc;
    assign instr     = r_instr;
    assign exec_en   = (r_state == S_EXEC);
    assign halted    = (r_state == S_HALT);
    assign pc        = w_pc;
    assign state     = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, halt_req;
    logic       imem_req, imem_ack, exec_en, load_PC, dmem_done, halted;
    logic [7:0] imem_addr, pc_value, pc;
    logic [9:0] imem_rdata, instr;
    logic [2:0] state;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step;
`endif

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .exec_en    (exec_en),
        .load_PC    (load_PC),
        .pc_value   (pc_value),
        .dmem_done  (dmem_done),
        .pc         (pc),
        .state      (state),
        .halted     (halted)
    );

    logic [9:0] mem [256];
    int checks = 0;
    int errors = 0;
    bit noise = 1'b0;
    int ack_dly = 1;
    int dmem_dly = 5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- environment: imem, decoder, dmem ----------------
    int ack_cnt = 0;
    int dm_cnt = 0;
    bit was_exec = 1'b0;
    initial begin
        imem_ack = 1'b0; imem_rdata = '0; load_PC = 1'b0; pc_value = '0; dmem_done = 1'b0;
    end
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (ack_cnt >= ack_dly) begin
                imem_ack = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack = 1'b0;
                imem_rdata = 10'($urandom);
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
            imem_ack = noise && ($urandom_range(0, 1) == 1);
            imem_rdata = 10'($urandom);
        end
        // Decoder with registered outputs: answers one cycle after exec_en.
        if (was_exec) begin
            load_PC  = (instr[9:6] == 4'h9) || (instr[9:6] == 4'hA);
            pc_value = (instr[9:6] == 4'hA) ? {2'b11, instr[5:0]} : {2'b00, instr[5:0]};
        end else begin
            load_PC  = noise && ($urandom_range(0, 1) == 1);
            pc_value = 8'($urandom);
        end
        was_exec = (exec_en === 1'b1);
        if (state === 3'd5) begin
            dmem_done = (dm_cnt == dmem_dly - 1);
            dm_cnt++;
        end else begin
            dm_cnt = 0;
            dmem_done = noise && ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- behavioural model + compare ----------------
    function automatic logic [7:0] model_next(input logic [9:0] w, input logic [7:0] p);
        case (w[9:6])
            4'h9:    return {2'b00, w[5:0]};
            4'hA:    return {2'b11, w[5:0]};
            4'h7:    return 8'h00;
            default: return p + 8'h01;
        endcase
    endfunction

    logic [7:0] m_pc = 8'h00;
    bit m_done = 1'b0;
    bit prev_req = 1'b0;
    int exec_total = 0;
    int mw_total = 0;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            m_pc = 8'h00;
            m_done = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (state === 3'd5) mw_total++;
            if (imem_req === 1'b1) begin
                if (!prev_req) m_done = 1'b0;
                chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
                chk("pc_at_fetch", 32'(pc), 32'(m_pc));
            end
            if (exec_en === 1'b1) begin
                exec_total++;
                chk("instr", 32'(instr), 32'(mem[m_pc]));
                chk("single_exec", 32'(m_done), 32'd0);
                m_done = 1'b1;
                m_pc = model_next(mem[m_pc], m_pc);
            end
            prev_req = (imem_req === 1'b1);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic next_fetch(input string tag);
        int n = 0;
        while (imem_req === 1'b1 && n < 200) begin @(negedge clk); n++; end
        while (imem_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: fetch timeout, actual=none required=imem_req", tag);
        end
    endtask

    task automatic fetch_at(input logic [7:0] addr, input string tag);
        int k = 0;
        do begin
            next_fetch(tag);
            k++;
        end while (imem_addr !== addr && k < 300);
        chk(tag, 32'(imem_addr), 32'(addr));
    endtask

    task automatic wait_halted(input logic lvl, input string tag);
        int n = 0;
        while (halted !== lvl && n < 200) begin @(negedge clk); n++; end
        chk(tag, 32'(halted), 32'(lvl));
    endtask

    int ex0, mw0;

    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 10'h3C0;
        mem[8'h00] = 10'h008;
        mem[8'h10] = 10'h25C;
        mem[8'h1C] = 10'h2C5;
        mem[8'h1D] = 10'h300;
        mem[8'h1E] = 10'h1C0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_exec_en", 32'(exec_en), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        noise = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'(state), 32'd0);

        // first instruction: ADD at 0x00
        run = 1'b1; @(negedge clk); run = 1'b0;
        chk("fetch0_addr", 32'(imem_addr), 32'h00);
        ex0 = exec_total;
        next_fetch("add_next");
        chk("add_next_addr", 32'(imem_addr), 32'h01);
        chk("add_pc", 32'(pc), 32'h01);
        chk("add_exec_cnt", 32'(exec_total - ex0), 32'd1);

        // jump at 0x10 -> 0x1C
        fetch_at(8'h10, "reach_jmp");
        next_fetch("jmp_next");
        chk("jmp_target", 32'(imem_addr), 32'h1C);
        chk("jmp_pc", 32'(pc), 32'h1C);

        // LOAD at 0x1C with five-cycle data-memory wait
        mw0 = mw_total; ex0 = exec_total;
        next_fetch("load_next");
        chk("load_memwait_cycles", 32'(mw_total - mw0), 32'd5);
        chk("load_exec_cnt", 32'(exec_total - ex0), 32'd1);
        chk("load_next_addr", 32'(imem_addr), 32'h1D);
        next_fetch("store_next");
        chk("store_next_addr", 32'(imem_addr), 32'h1E);
        next_fetch("rst_op_next");
        chk("rst_op_addr", 32'(imem_addr), 32'h00);

        // halt request during the fetch at 0x05
        fetch_at(8'h05, "reach_05");
        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        wait_halted(1'b1, "halt_reached");
        chk("halt_pc", 32'(pc), 32'h06);
        chk("halt_state", 32'(state), 32'd6);
        ex0 = exec_total;
        repeat (3) @(negedge clk);
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_no_exec", 32'(exec_total - ex0), 32'd0);
        run = 1'b1; halt_req = 1'b1; @(negedge clk); run = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        chk("run_with_halt_req", 32'(state), 32'd6);

        // resume at 0x06, far jump to 0xFF, NOP wraps to 0x00
        mem[8'h06] = 10'h2BF;
        run = 1'b1; @(negedge clk); run = 1'b0;
        chk("resume_addr", 32'(imem_addr), 32'h06);
        next_fetch("far_jmp");
        chk("far_jmp_addr", 32'(imem_addr), 32'hFF);
        chk("pend_cleared", 32'(halted), 32'd0);
        next_fetch("wrap");
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        chk("wrap_pc", 32'(pc), 32'h00);

        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        wait_halted(1'b1, "halt2_reached");
        chk("halt2_pc", 32'(pc), 32'h01);

`ifdef SEQ_SINGLE_STEP_EN
        ex0 = exec_total;
        step = 1'b1; @(negedge clk); step = 1'b0;
        wait_halted(1'b0, "step_left_halt");
        wait_halted(1'b1, "step_back_halt");
        chk("step_exec_cnt", 32'(exec_total - ex0), 32'd1);
        chk("step_pc", 32'(pc), 32'h02);
        repeat (3) @(negedge clk);
        chk("step_stays_halted", 32'(halted), 32'd1);
`endif

        // reset in the middle of a fetch
        run = 1'b1; @(negedge clk); run = 1'b0;
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_instr", 32'(instr), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(state), 32'd0);
        run = 1'b1; @(negedge clk); run = 1'b0;
        ex0 = exec_total;
        next_fetch("post_rst_run");
        chk("post_rst_addr", 32'(imem_addr), 32'h01);
        chk("post_rst_exec", 32'(exec_total - ex0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port run  in  1  start execution from IDLE or HALT.
REQ-004 SHALL have port halt_req  in  1  stop after the current instruction completes.
REQ-005 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  out  8  fetch address, equal to pc.
REQ-007 SHALL have port imem_ack  in  1  read-data-valid strobe from instruction memory.
REQ-008 SHALL have port imem_rdata  in  10  fetched word iiiidddddd.
REQ-009 SHALL have port instr  out  10  instruction register driving the decoder.
REQ-010 SHALL have port exec_en  out  1  one-cycle strobe telling the decoder to act on instr.
REQ-011 SHALL have port load_PC  in  1  jump request from the decoder.
REQ-012 SHALL have port pc_value  in  8  jump target from the decoder.
REQ-013 SHALL have port dmem_done  in  1  data-memory LOAD/STORE completion strobe.
REQ-014 SHALL have ports pc  out  8, state  out  3, halted  out  1: status.

Function
REQ-015 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, COMMIT=4, MEMWAIT=5, HALT=6.
REQ-016 IDLE: run=1 -> FETCH; otherwise stay.
REQ-017 FETCH: imem_req=1 with imem_addr=pc held stable until imem_ack; on ack, instr<=imem_rdata, -> DECODE; imem_req low the following cycle.
REQ-018 DECODE: single cycle, instr stable, -> EXEC.
REQ-019 EXEC: exec_en=1 for exactly this cycle, -> COMMIT.
REQ-020 COMMIT (decoder outputs are registered, so load_PC is valid here): opcode 1011 or 1100 -> MEMWAIT; otherwise update PC per REQ-022.
REQ-021 MEMWAIT: wait for dmem_done, no timeout; on dmem_done, pc<=pc+1.
REQ-022 PC update: load_PC=1 -> pc<=pc_value; opcode 0111 -> pc<=0; otherwise pc<=pc+1, 8-bit wrap 0xFF->0x00.
REQ-023 After any PC update: halt_pend=1 -> HALT, else -> FETCH.
REQ-024 halt_req SHALL set a sticky halt_pend in any state; halt_pend clears on HALT exit.
REQ-025 HALT: halted=1; run=1 with halt_req=0 -> FETCH at current pc; run and halt_req both high -> stay in HALT.
REQ-026 imem_ack outside FETCH, load_PC outside COMMIT, and dmem_done outside MEMWAIT SHALL be ignored.
REQ-027 Opcodes 1101-1111 SHALL be executed as NOP (pc+1).
REQ-028 Instruction latency, zero memory wait: FETCH->commit is 4 cycles minimum.

Reset
REQ-029 On reset: state=IDLE, pc=0, instr=0, exec_en=0, imem_req=0, halted=0, halt_pend=0, applied immediately, including mid-fetch or mid-MEMWAIT.

Configuration
REQ-030 Macro SEQ_SINGLE_STEP_EN defined: input step (1 bit) exists; step=1 in HALT executes exactly one instruction (FETCH..commit) and then returns to HALT regardless of halt_pend.
REQ-031 Macro SEQ_SINGLE_STEP_EN undefined: no step port; HALT is exited only via run.

Structure
REQ-032 Package cpu_seq_pkg SHALL hold the state encoding, PC_W=8, INSTR_W=10, OP_RST=4'b0111, OP_LOAD=4'b1011, OP_STORE=4'b1100.
REQ-033 PC register plus next-PC mux SHALL be a sub-module seq_pc_unit; the FSM remains in instr_sequencer.

Verification
REQ-034 Reset, run=1, memory at 0x00 holds 0x008 (ADD), imem_ack 1 cycle after req -> exec_en one pulse, pc=0x01, next imem_addr=0x01.
REQ-035 JMP 0x25C at pc=0x10, decoder returns load_PC=1, pc_value=0x1C -> pc=0x1C, next fetch at 0x1C.
REQ-036 LOAD 0x2C5, dmem_done delayed 5 cycles -> state=MEMWAIT for 5 cycles, then pc+1, no extra exec_en.
REQ-037 halt_req pulsed during FETCH at pc=0x05 -> instruction completes, pc=0x06, halted=1; then run=1 -> fetch at 0x06.
REQ-038 pc=0xFF with NOP opcode 0xF -> pc wraps to 0x00; reset asserted while imem_req=1 -> imem_req=0 immediately, state=IDLE.
REQ-039 With SEQ_SINGLE_STEP_EN: in HALT, step pulse -> exactly one exec_en, return to HALT, pc advanced by one.
